// File: rtl/pmc_code_mem_pkg.sv
// Shared types and helpers for the PMC program memory.
// Parity option is selected by the PMC_CODE_MEM_PARITY_EN macro.
package pmc_code_mem_pkg;

    localparam int FETCH_CH_MAX = 4;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  par_t;

    function automatic par_t byte_parity(input word_t w);
        par_t p;
        for (int b = 0; b < 4; b++) begin
            p[b] = ^w[8*b +: 8];
        end
        return p;
    endfunction

    function automatic logic range_ok(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int          addr_w
    );
        logic [31:0] w_diff;
        w_diff = (addr ^ base) >> (addr_w + 2);
        return (w_diff == '0);
    endfunction

endpackage

// File: rtl/pmc_code_mem_bank.sv
// Word array: one byte-enable write port, one data read port and
// FETCH_CH fetch read ports, all read-before-write. PMC_CODE_MEM_PARITY_EN adds parity.
module pmc_code_mem_bank
    import pmc_code_mem_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int FETCH_CH = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_we,
    input  logic [ADDR_W-1:0]          i_waddr,
    input  logic [3:0]                 i_be,
    input  logic [31:0]                i_wdata,
    input  logic                       i_re,
    input  logic [ADDR_W-1:0]          i_raddr,
    output logic [31:0]                o_rdata,
    output logic                       o_rperr,
    input  logic [FETCH_CH-1:0]        i_fetch_req,
    input  logic [FETCH_CH*ADDR_W-1:0] i_fetch_addr,
    output logic [FETCH_CH*32-1:0]     o_fetch_data,
    output logic [FETCH_CH-1:0]        o_fetch_perr
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;
    logic [31:0] r_fdata [FETCH_CH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Output registers are cleared on reset; the array itself is not.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
            for (int ch = 0; ch < FETCH_CH; ch++) begin
                r_fdata[ch] <= '0;
            end
        end else begin
            if (i_re) begin
                r_rdata <= r_mem[i_raddr];
            end
            for (int ch = 0; ch < FETCH_CH; ch++) begin
                if (i_fetch_req[ch]) begin
                    r_fdata[ch] <= r_mem[i_fetch_addr[ch*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    assign o_rdata = r_rdata;

    for (genvar ch = 0; ch < FETCH_CH; ch++) begin : g_fout
        assign o_fetch_data[ch*32 +: 32] = r_fdata[ch];
    end

`ifdef PMC_CODE_MEM_PARITY_EN
    logic [3:0] r_par [DEPTH];
    logic [3:0] r_rpar;
    logic [3:0] r_fpar [FETCH_CH];
    par_t       w_wpar;

    assign w_wpar = byte_parity(i_wdata);

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_par[i_waddr][b] <= w_wpar[b];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rpar <= '0;
            for (int ch = 0; ch < FETCH_CH; ch++) begin
                r_fpar[ch] <= '0;
            end
        end else begin
            if (i_re) begin
                r_rpar <= r_par[i_raddr];
            end
            for (int ch = 0; ch < FETCH_CH; ch++) begin
                if (i_fetch_req[ch]) begin
                    r_fpar[ch] <= r_par[i_fetch_addr[ch*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    assign o_rperr = |(byte_parity(r_rdata) ^ r_rpar);

    for (genvar ch = 0; ch < FETCH_CH; ch++) begin : g_fperr
        assign o_fetch_perr[ch] = |(byte_parity(r_fdata[ch]) ^ r_fpar[ch]);
    end

    // Verification hook: flips the byte-0 parity bit of one word.
    task automatic force_perr(input logic [ADDR_W-1:0] idx);
        r_par[idx][0] = ~r_par[idx][0];
    endtask
`else
    assign o_rperr      = 1'b0;
    assign o_fetch_perr = '0;
`endif

endmodule

// File: rtl/pmc_code_mem.sv
// PMC program memory: data-bus slave with range/lock checks plus fetch ports.
// Optional per-byte parity is enabled by defining PMC_CODE_MEM_PARITY_EN.
module pmc_code_mem
    import pmc_code_mem_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          FETCH_CH  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_bus_req,
    output logic                       o_bus_gnt,
    input  logic [31:0]                i_bus_addr,
    input  logic                       i_bus_we,
    input  logic [3:0]                 i_bus_be,
    input  logic [31:0]                i_bus_wdata,
    output logic [31:0]                o_bus_rdata,
    output logic [6:0]                 o_bus_rdata_intg,
    output logic                       o_bus_rvalid,
    output logic                       o_bus_err,
    input  logic [FETCH_CH-1:0]        i_fetch_req,
    input  logic [FETCH_CH*ADDR_W-1:0] i_fetch_addr,
    output logic [FETCH_CH*32-1:0]     o_fetch_instr,
    output logic [FETCH_CH-1:0]        o_fetch_valid,
    output logic [FETCH_CH-1:0]        o_fetch_perr,
    input  logic                       i_lock,
    output logic                       o_locked
);

    logic              w_in_range;
    logic [ADDR_W-1:0] w_widx;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_acc_err;
    logic [31:0]       w_bank_rdata;
    logic              w_rperr;
    logic [FETCH_CH-1:0] w_fperr;
    logic              w_unused;

    logic                r_rvalid;
    logic                r_acc_err;
    logic                r_rd_ok;
    logic                r_locked;
    logic [FETCH_CH-1:0] r_fvalid;

    assign w_in_range = range_ok(i_bus_addr, BASE_ADDR, ADDR_W);
    assign w_widx     = i_bus_addr[ADDR_W+1:2];
    assign w_unused   = ^i_bus_addr[1:0];

    // Lock is sampled from the flop, so a write alongside the lock pulse still lands.
    assign w_wr_ok   = i_bus_req & i_bus_we & w_in_range & ~r_locked & ~i_rst;
    assign w_rd_ok   = i_bus_req & ~i_bus_we & w_in_range;
    assign w_acc_err = i_bus_req & (~w_in_range | (i_bus_we & r_locked));

    pmc_code_mem_bank #(
        .ADDR_W   (ADDR_W),
        .FETCH_CH (FETCH_CH)
    ) u_bank (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_we         (w_wr_ok),
        .i_waddr      (w_widx),
        .i_be         (i_bus_be),
        .i_wdata      (i_bus_wdata),
        .i_re         (w_rd_ok),
        .i_raddr      (w_widx),
        .o_rdata      (w_bank_rdata),
        .o_rperr      (w_rperr),
        .i_fetch_req  (i_fetch_req),
        .i_fetch_addr (i_fetch_addr),
        .o_fetch_data (o_fetch_instr),
        .o_fetch_perr (w_fperr)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rvalid  <= 1'b0;
            r_acc_err <= 1'b0;
            r_rd_ok   <= 1'b0;
            r_locked  <= 1'b0;
            r_fvalid  <= '0;
        end else begin
            r_rvalid  <= i_bus_req;
            r_acc_err <= w_acc_err;
            r_rd_ok   <= w_rd_ok;
            r_locked  <= r_locked | i_lock;
            r_fvalid  <= i_fetch_req;
        end
    end

    assign o_bus_gnt        = i_bus_req;
    assign o_bus_rdata      = r_rd_ok ? w_bank_rdata : 32'h0;
    assign o_bus_rdata_intg = 7'b0;
    assign o_bus_rvalid     = r_rvalid;
    assign o_bus_err        = r_rvalid & (r_acc_err | (r_rd_ok & w_rperr));
    assign o_fetch_valid    = r_fvalid;
    assign o_fetch_perr     = r_fvalid & w_fperr;
    assign o_locked         = r_locked;

endmodule

// File: tb/tb_pmc_code_mem.sv
// Directed self-checking bench for pmc_code_mem (ADDR_W=10, FETCH_CH=2, BASE=0).
module tb_pmc_code_mem;

    localparam int AW = 10;
    localparam int FC = 2;

`ifdef PMC_CODE_MEM_PARITY_EN
    localparam logic EXP_P = 1'b1;
`else
    localparam logic EXP_P = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           req;
    logic           gnt;
    logic [31:0]    addr;
    logic           we;
    logic [3:0]     be;
    logic [31:0]    wdata;
    logic [31:0]    rdata;
    logic [6:0]     intg;
    logic           rvalid;
    logic           err;
    logic [FC-1:0]  freq;
    logic [FC*AW-1:0] faddr;
    logic [FC*32-1:0] finstr;
    logic [FC-1:0]  fvalid;
    logic [FC-1:0]  fperr;
    logic           lock;
    logic           locked;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pmc_code_mem #(
        .ADDR_W    (AW),
        .FETCH_CH  (FC),
        .BASE_ADDR (32'h0)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_bus_req        (req),
        .o_bus_gnt        (gnt),
        .i_bus_addr       (addr),
        .i_bus_we         (we),
        .i_bus_be         (be),
        .i_bus_wdata      (wdata),
        .o_bus_rdata      (rdata),
        .o_bus_rdata_intg (intg),
        .o_bus_rvalid     (rvalid),
        .o_bus_err        (err),
        .i_fetch_req      (freq),
        .i_fetch_addr     (faddr),
        .o_fetch_instr    (finstr),
        .o_fetch_valid    (fvalid),
        .o_fetch_perr     (fperr),
        .i_lock           (lock),
        .o_locked         (locked)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req  = 1'b0;
        we   = 1'b0;
        be   = 4'h0;
        addr = '0;
        wdata = '0;
        freq = '0;
        lock = 1'b0;
    endtask

    task automatic drv(input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
        req   = 1'b1;
        we    = w;
        addr  = a;
        be    = b;
        wdata = d;
    endtask

    initial begin
        idle();
        faddr = '0;
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_fvalid", {30'b0, fvalid}, 32'h0);
        chk("rst_finstr0", finstr[31:0], 32'h0);
        chk("rst_finstr1", finstr[63:32], 32'h0);
        chk("rst_fperr", {30'b0, fperr}, 32'h0);
        chk("rst_locked", {31'b0, locked}, 32'h0);
        rst = 1'b0;

        // Full write, partial write, read back
        drv(1'b1, 32'h14, 4'hF, 32'hDEADBEEF);
        #1;
        chk("gnt", {31'b0, gnt}, 32'h1);
        cyc();
        chk("wr_rvalid", {31'b0, rvalid}, 32'h1);
        chk("wr_err", {31'b0, err}, 32'h0);
        drv(1'b1, 32'h14, 4'b0010, 32'h0000AA00);
        cyc();
        drv(1'b0, 32'h14, 4'h0, 32'h0);
        cyc();
        chk("rd5_rvalid", {31'b0, rvalid}, 32'h1);
        chk("rd5_rdata", rdata, 32'hDEADAAEF);
        chk("rd5_err", {31'b0, err}, 32'h0);
        chk("intg", {25'b0, intg}, 32'h0);
        idle();
        cyc();
        chk("idle_rvalid", {31'b0, rvalid}, 32'h0);

        // Collision: write word 7 while both fetch ports read it
        drv(1'b1, 32'h1C, 4'hF, 32'h22222222);
        cyc();
        drv(1'b1, 32'h1C, 4'hF, 32'h11111111);
        freq  = 2'b11;
        faddr = {10'd7, 10'd7};
        cyc();
        chk("col_fvalid", {30'b0, fvalid}, 32'h3);
        chk("col_f0", finstr[31:0], 32'h22222222);
        chk("col_f1", finstr[63:32], 32'h22222222);
        req = 1'b0;
        cyc();
        chk("col_f0_new", finstr[31:0], 32'h11111111);
        chk("col_f1_new", finstr[63:32], 32'h11111111);
        freq = 2'b00;
        cyc();
        chk("hold_fvalid", {30'b0, fvalid}, 32'h0);
        chk("hold_f0", finstr[31:0], 32'h11111111);

        // Range check
        drv(1'b1, 32'h0, 4'hF, 32'hA5A5A5A5);
        cyc();
        drv(1'b1, 32'h1000, 4'hF, 32'hCAFEF00D);
        cyc();
        chk("oor_wr_rvalid", {31'b0, rvalid}, 32'h1);
        chk("oor_wr_err", {31'b0, err}, 32'h1);
        drv(1'b0, 32'h1000, 4'h0, 32'h0);
        cyc();
        chk("oor_rd_rdata", rdata, 32'h0);
        chk("oor_rd_err", {31'b0, err}, 32'h1);
        drv(1'b0, 32'h0, 4'h0, 32'h0);
        cyc();
        chk("oor_w0_intact", rdata, 32'hA5A5A5A5);
        chk("oor_w0_err", {31'b0, err}, 32'h0);

        // Lock: a write alongside the pulse commits, later writes drop
        drv(1'b1, 32'h4, 4'hF, 32'h0BADCAFE);
        lock = 1'b1;
        cyc();
        lock = 1'b0;
        chk("lock_same_err", {31'b0, err}, 32'h0);
        chk("locked_set", {31'b0, locked}, 32'h1);
        drv(1'b1, 32'h0, 4'hF, 32'h12345678);
        cyc();
        chk("lock_wr_err", {31'b0, err}, 32'h1);
        drv(1'b0, 32'h0, 4'h0, 32'h0);
        cyc();
        chk("lock_w0_intact", rdata, 32'hA5A5A5A5);
        drv(1'b0, 32'h4, 4'h0, 32'h0);
        cyc();
        chk("lock_w1_commit", rdata, 32'h0BADCAFE);
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("lock_clear", {31'b0, locked}, 32'h0);
        drv(1'b1, 32'h0, 4'hF, 32'h12345678);
        cyc();
        chk("unlock_wr_err", {31'b0, err}, 32'h0);
        drv(1'b0, 32'h0, 4'h0, 32'h0);
        cyc();
        chk("unlock_w0", rdata, 32'h12345678);

        // Reset mid-stream
        drv(1'b0, 32'h14, 4'h0, 32'h0);
        cyc();
        chk("ms_n1", {31'b0, rvalid}, 32'h1);
        cyc();
        chk("ms_n2", {31'b0, rvalid}, 32'h1);
        drv(1'b1, 32'h14, 4'hF, 32'hFFFFFFFF);
        freq = 2'b01;
        faddr = {10'd0, 10'd5};
        rst = 1'b1;
        cyc();
        chk("ms_n3", {31'b0, rvalid}, 32'h0);
        chk("ms_n3_fv", {30'b0, fvalid}, 32'h0);
        drv(1'b0, 32'h14, 4'h0, 32'h0);
        freq = 2'b00;
        cyc();
        chk("ms_n4", {31'b0, rvalid}, 32'h0);
        rst = 1'b0;
        cyc();
        chk("ms_rd_after", rdata, 32'hDEADAAEF);
        idle();

        // Parity injection on word 3
        drv(1'b1, 32'hC, 4'hF, 32'h0F0F0F0F);
        cyc();
        idle();
`ifdef PMC_CODE_MEM_PARITY_EN
        dut.u_bank.force_perr(10'd3);
`endif
        drv(1'b0, 32'hC, 4'h0, 32'h0);
        freq  = 2'b01;
        faddr = {10'd0, 10'd3};
        cyc();
        idle();
        chk("par_rdata", rdata, 32'h0F0F0F0F);
        chk("par_err", {31'b0, err}, {31'b0, EXP_P});
        chk("par_fperr", {30'b0, fperr}, {31'b0, EXP_P});
        chk("par_f0", finstr[31:0], 32'h0F0F0F0F);

        cyc();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
